mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the unified instruction/data memory. The multicycle core controller (fetch, load, store) shares the single memory port with the program loader (boot/debug write-in, readback). The block serializes accesses, tracks the memory's fixed read latency, and returns read data to the winning requester. It sits between the core's memory address/data path and the memory macro.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide
- RD_LAT, 1, memory read latency in cycles, legal 1..4

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- core_req / ldr_req  in  1  access request; held with command fields until gnt
- core_we / ldr_we  in  1  1 = write, 0 = read
- core_addr / ldr_addr  in  ADDR_W  byte address
- core_wdata / ldr_wdata  in  DATA_W  write data
- core_wstrb / ldr_wstrb  in  DATA_W/8  byte enables, writes only
- core_gnt / ldr_gnt  out  1  one-cycle pulse: command accepted
- core_rvalid / ldr_rvalid  out  1  one-cycle pulse: rdata valid
- core_rdata / ldr_rdata  out  DATA_W  read data, both driven from mem_rdata
- ldr_lock  in  1  loader burst lock
- busy  out  1  state != IDLE
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- mem_wstrb  out  DATA_W/8
- mem_rdata  in  DATA_W  valid RD_LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req, choose a winner, register owner, we, addr, wdata, wstrb, then go to ISSUE; otherwise stay.
- ISSUE: mem_en=1, mem_* driven from the registered command, owner gnt=1. Write goes to IDLE. Read loads wait counter with RD_LAT and goes to WAIT.
- WAIT: counter decrements each cycle. In the cycle the counter equals 1, owner rvalid=1, then go to IDLE.
- Arbitration in round-robin mode: the requester that did not win last gets priority. The last-winner register resets to loader, so the core wins the first tie.
- Lock: if ldr_lock=1, the last winner is loader, and ldr_req=1, the loader wins regardless of core_req. The lock is ignored while the loader is not the last winner.
- The non-owner's gnt and rvalid stay 0 at all times. Requests that arrive outside IDLE wait.
- A requester may drop or change req only after gnt. Dropping req before gnt is legal: it is simply not served.
- Reset (also mid-read): state IDLE, counter 0, last-winner loader. All gnt, rvalid, mem_en, mem_we, busy are 0. All mem_addr, mem_wdata, mem_wstrb are 0. An in-flight read produces no rvalid.

## Timing
- req seen in IDLE at cycle 0 → gnt and mem_en at cycle 1.
- Write occupies 2 cycles: earliest next issue is cycle 3.
- Read: rvalid at cycle 1+RD_LAT, same cycle as memory data. Back in IDLE at cycle 2+RD_LAT; earliest next issue is cycle 3+RD_LAT.
- rdata is combinational from mem_rdata and is only meaningful while rvalid=1.
- Outputs mem_*, gnt, rvalid, busy are functions of registered state only; there is no combinational path from req.

## Configuration
- CORE_FIXED_PRIORITY_EN defined: core always wins a tie. The last-winner register and ldr_lock are unused. The loader can be starved by continuous core requests.
- Not defined: round-robin with ldr_lock, as described above.

## Test plan
- Core read, RD_LAT=2, addr 0x0000_0010, memory returns 0xDEAD_BEEF → core_gnt at cycle 1, core_rvalid with rdata 0xDEAD_BEEF at cycle 3, busy high for cycles 1–3, ldr_* outputs stay 0.
- Loader write to 0x40, data 0x1234_5678, strobe 0xF → mem_en=mem_we=1 at cycle 1 with those values, ldr_gnt at cycle 1, no rvalid, IDLE at cycle 2.
- Both request reads continuously (round-robin) → grants alternate core, ldr, core, ldr, with no grant issued while busy.
- ldr_lock=1 with both requesting after one loader win → loader granted on 3 consecutive accesses. Drop the lock → the core wins the next one.
- rst asserted in WAIT with RD_LAT=3 → next cycle all outputs 0, no rvalid ever. A core request after reset is served first.
- With CORE_FIXED_PRIORITY_EN, both requesting writes for 4 accesses → only core_gnt pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester memory port arbiter/sequencer; define CORE_FIXED_PRIORITY_EN for fixed core priority
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wstrb,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [ADDR_W-1:0]   ldr_addr,
    input  logic [DATA_W-1:0]   ldr_wdata,
    input  logic [DATA_W/8-1:0] ldr_wstrb,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [DATA_W-1:0]   ldr_rdata,
    input  logic                ldr_lock,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  ldr_wins, issue, done;
`ifdef CORE_FIXED_PRIORITY_EN
    logic unused_lock;
    assign unused_lock = ldr_lock;
    assign ldr_wins = ldr_req && !core_req;
`else
    logic last_q, last_d;
    assign ldr_wins = ldr_req && (!core_req || !last_q || ldr_lock);
    // remember who won the most recent arbitration
    always_comb last_d = (state_q == IDLE && (core_req || ldr_req)) ? ldr_wins : last_q;
    // last winner resets to loader so the core wins the first tie
    always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
`endif
    // sequencing: latch winning command in IDLE, issue it, then count out read latency
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (core_req || ldr_req) begin
                state_d = ISSUE;
                owner_d = ldr_wins;
                we_d    = ldr_wins ? ldr_we    : core_we;
                addr_d  = ldr_wins ? ldr_addr  : core_addr;
                wdata_d = ldr_wins ? ldr_wdata : core_wdata;
                wstrb_d = ldr_wins ? ldr_wstrb : core_wstrb;
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
                cnt_d   = we_q ? cnt_q : 3'(RD_LAT);
            end
            WAIT: begin
                cnt_d   = cnt_q - 3'd1;
                state_d = (cnt_q == 3'd1) ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
        end
    end
    assign issue       = state_q == ISSUE;
    assign done        = state_q == WAIT && cnt_q == 3'd1;
    assign busy        = state_q != IDLE;
    assign mem_en      = issue;
    assign mem_we      = issue && we_q;
    assign mem_addr    = issue ? addr_q  : '0;
    assign mem_wdata   = issue ? wdata_q : '0;
    assign mem_wstrb   = issue ? wstrb_q : '0;
    assign core_gnt    = issue && !owner_q;
    assign ldr_gnt     = issue && owner_q;
    assign core_rvalid = done && !owner_q;
    assign ldr_rvalid  = done && owner_q;
    assign core_rdata  = mem_rdata;
    assign ldr_rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter at RD_LAT=2 and RD_LAT=3
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, ldr_req, ldr_we, ldr_lock;
    logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
    logic [3:0]  core_wstrb, ldr_wstrb;
    logic        core_gnt, core_rvalid, ldr_gnt, ldr_rvalid, busy, mem_en, mem_we;
    logic [31:0] core_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        core_gnt_3, core_rvalid_3, ldr_gnt_3, ldr_rvalid_3, busy_3, mem_en_3, mem_we_3;
    logic [31:0] core_rdata_3, ldr_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_wstrb_3;
    logic [31:0] pipe2 [2];
    logic [31:0] pipe3 [3];
    logic [6:0]  ctl, ctl3;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wstrb(core_wstrb), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_wstrb(ldr_wstrb), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .ldr_lock(ldr_lock), .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wstrb(core_wstrb), .core_gnt(core_gnt_3), .core_rvalid(core_rvalid_3), .core_rdata(core_rdata_3),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_wstrb(ldr_wstrb), .ldr_gnt(ldr_gnt_3), .ldr_rvalid(ldr_rvalid_3), .ldr_rdata(ldr_rdata_3),
        .ldr_lock(ldr_lock), .busy(busy_3), .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_wstrb(mem_wstrb_3), .mem_rdata(mem_rdata_3)
    );

    assign ctl  = {core_gnt, core_rvalid, ldr_gnt, ldr_rvalid, busy, mem_en, mem_we};
    assign ctl3 = {core_gnt_3, core_rvalid_3, ldr_gnt_3, ldr_rvalid_3, busy_3, mem_en_3, mem_we_3};

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], 16'hA5A5};
    endfunction

    // memory models: read data appears RD_LAT cycles after the mem_en cycle
    always_ff @(posedge clk) begin
        pipe2[0] <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'h0;
        pipe2[1] <= pipe2[0];
        pipe3[0] <= (mem_en_3 && !mem_we_3) ? mem_val(mem_addr_3) : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata   = pipe2[1];
    assign mem_rdata_3 = pipe3[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_req = 1'b1;
        step();
        step();
        tests++;
        if (ctl !== 7'b0) begin fails++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0); end
        tests++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
            fails++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, mem_wstrb});
        end
        tests++;
        if (ctl3 !== 7'b0) begin fails++; $display("FAIL reset_ctl3: got %b want %b", ctl3, 7'b0); end
        core_req = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_core_read();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        step();
        tests++;
        if ({ctl, mem_addr} !== {7'b1000110, 32'h10}) begin
            fails++; $display("FAIL core_read_c1: got %b/%h want %b/%h", ctl, mem_addr, 7'b1000110, 32'h10);
        end
        core_req = 1'b0;
        step();
        tests++;
        if (ctl !== 7'b0000100) begin fails++; $display("FAIL core_read_c2: got %b want %b", ctl, 7'b0000100); end
        step();
        tests++;
        if ({ctl, core_rdata} !== {7'b0100100, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL core_read_c3: got %b/%h want %b/%h", ctl, core_rdata, 7'b0100100, 32'hDEAD_BEEF);
        end
        step();
        tests++;
        if (ctl !== 7'b0) begin fails++; $display("FAIL core_read_c4: got %b want %b", ctl, 7'b0); end
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'h1234_5678; ldr_wstrb = 4'hF;
        step();
        tests++;
        if (ctl !== 7'b0010111) begin fails++; $display("FAIL ldr_write_ctl: got %b want %b", ctl, 7'b0010111); end
        tests++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h40, 32'h1234_5678, 4'hF}) begin
            fails++; $display("FAIL ldr_write_mem: got %h/%h/%h want 40/12345678/f", mem_addr, mem_wdata, mem_wstrb);
        end
        ldr_req = 1'b0;
        step();
        tests++;
        if (ctl !== 7'b0) begin fails++; $display("FAIL ldr_write_c2: got %b want %b", ctl, 7'b0); end
        step();
        tests++;
        if (ctl !== 7'b0) begin fails++; $display("FAIL ldr_write_c3: got %b want %b", ctl, 7'b0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        int ng;
        seq = 4'b0;
        ng = 0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h200;
        for (int i = 1; i <= 16; i++) begin
            step();
            tests++;
            if (core_gnt && ldr_gnt) begin fails++; $display("FAIL rr_dual_gnt: got 11 want one-hot at cycle %0d", i); end
            if ((core_gnt || ldr_gnt) && ng < 4) begin
                seq[ng] = ldr_gnt;
                tests++;
                if ({i, mem_addr} !== {1 + 4 * ng, ldr_gnt ? 32'h200 : 32'h100}) begin
                    fails++; $display("FAIL rr_gnt_timing: got cycle %0d addr %h want cycle %0d", i, mem_addr, 1 + 4 * ng);
                end
                ng++;
            end
            if ((core_rvalid || ldr_rvalid) && ng > 0) begin
                tests++;
                if ({i == 4 * ng - 1, ldr_rvalid, ldr_rvalid ? ldr_rdata : core_rdata} !==
                    {1'b1, seq[ng-1], mem_val(seq[ng-1] ? 32'h200 : 32'h100)}) begin
                    fails++; $display("FAIL rr_rvalid: got cycle %0d ldr %b data %h", i, ldr_rvalid, ldr_rvalid ? ldr_rdata : core_rdata);
                end
            end
            if (i == 15) begin core_req = 1'b0; ldr_req = 1'b0; end
        end
        tests++;
        if ({ng, seq} !== {32'd4, 4'b1010}) begin fails++; $display("FAIL rr_sequence: got %0d grants %b want 4 grants 1010", ng, seq); end
    endtask

    task automatic test_lock();
        logic [6:0] exp_l, exp_c;
        exp_l = 7'b0010101;
        exp_c = 7'b1000000;
        ldr_lock = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h300; core_wdata = 32'h1; core_wstrb = 4'h3;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h400; ldr_wdata = 32'h2; ldr_wstrb = 4'hC;
        for (int i = 1; i <= 7; i++) begin
            step();
            tests++;
            if ({core_gnt, ldr_gnt} !== {exp_c[i-1], exp_l[i-1]}) begin
                fails++; $display("FAIL lock_gnt cycle %0d: got %b%b want %b%b", i, core_gnt, ldr_gnt, exp_c[i-1], exp_l[i-1]);
            end
            if (i == 5) ldr_lock = 1'b0;
            if (i == 7) begin core_req = 1'b0; ldr_req = 1'b0; end
        end
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL lock_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_fixed_priority();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h500; core_wdata = 32'h5; core_wstrb = 4'hF;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h600; ldr_wdata = 32'h6; ldr_wstrb = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            step();
            tests++;
            if ({core_gnt, ldr_gnt} !== ((i % 2 == 1) ? 2'b10 : 2'b00)) begin
                fails++; $display("FAIL fixed_gnt cycle %0d: got %b%b", i, core_gnt, ldr_gnt);
            end
            if (i == 8) begin core_req = 1'b0; ldr_req = 1'b0; end
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        step();
        tests++;
        if (ctl3 !== 7'b1000110) begin fails++; $display("FAIL rstw_c1: got %b want %b", ctl3, 7'b1000110); end
        core_req = 1'b0;
        step();
        tests++;
        if (ctl3 !== 7'b0000100) begin fails++; $display("FAIL rstw_c2: got %b want %b", ctl3, 7'b0000100); end
        rst = 1'b1;
        step();
        tests++;
        if ({ctl3, ctl} !== 14'b0) begin fails++; $display("FAIL rstw_ctl: got %b/%b want 0/0", ctl3, ctl); end
        tests++;
        if ({mem_addr_3, mem_wdata_3, mem_wstrb_3} !== 68'h0) begin
            fails++; $display("FAIL rstw_mem: got %h want 0", {mem_addr_3, mem_wdata_3, mem_wstrb_3});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if ({ctl3, ctl} !== 14'b0) begin fails++; $display("FAIL rstw_quiet %0d: got %b/%b want 0/0", i, ctl3, ctl); end
        end
        core_req = 1'b1; core_addr = 32'h10;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h200;
        step();
        tests++;
        if ({ctl3, ctl} !== {7'b1000110, 7'b1000110}) begin
            fails++; $display("FAIL rstw_core_first: got %b/%b want 1000110/1000110", ctl3, ctl);
        end
        core_req = 1'b0; ldr_req = 1'b0;
        step();
        step();
        step();
        tests++;
        if ({ctl3, core_rdata_3} !== {7'b0100100, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL rstw_lat3: got %b/%h want %b/%h", ctl3, core_rdata_3, 7'b0100100, 32'hDEAD_BEEF);
        end
        step();
        tests++;
        if (ctl3 !== 7'b0) begin fails++; $display("FAIL rstw_end: got %b want %b", ctl3, 7'b0); end
    endtask

    initial begin
        rst = 1'b1; ldr_lock = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wstrb = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_wstrb = '0;
        test_reset();
        test_core_read();
        test_ldr_write();
`ifdef CORE_FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_round_robin();
        test_lock();
`endif
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
